// File: rtl/pifo_lane_client.sv
// Initiator side of one PIFO-tree lane: issues push/pop tasks under occupancy and credit
// limits, and buffers level-0 pop returns in a first-word-fall-through response FIFO.
module pifo_lane_client #(
    parameter int PTW       = 16,
    parameter int MTW       = 0,
    parameter int TREE_NUM  = 4,
    parameter int TREE_CAP  = 15,
    parameter int RSP_DEPTH = 4,
    localparam int TNB = $clog2(TREE_NUM),
    localparam int DW  = MTW + PTW,
    localparam int OCW = $clog2(TREE_CAP + 1),
    localparam int CRW = $clog2(RSP_DEPTH + 1),
    localparam int AW  = $clog2(RSP_DEPTH)
) (
    input  logic           i_clk,
    input  logic           i_arst_n,
    input  logic           i_cmd_valid,
    output logic           o_cmd_ready,
    input  logic           i_cmd_op,
    input  logic [TNB-1:0] i_cmd_tree_id,
    input  logic [DW-1:0]  i_cmd_data,
    output logic           o_push,
    output logic           o_pop,
    output logic [TNB-1:0] o_push_tree_id,
    output logic [TNB-1:0] o_pop_tree_id,
    output logic [DW-1:0]  o_push_data,
    input  logic           i_task_fifo_full,
    input  logic           i_is_level0_pop,
    input  logic [TNB-1:0] i_tree_id,
    input  logic [DW-1:0]  i_pop_data,
    output logic           o_rsp_valid,
    input  logic           i_rsp_ready,
    output logic [TNB-1:0] o_rsp_tree_id,
    output logic [DW-1:0]  o_rsp_data,
    output logic           o_rsp_null,
    output logic           o_err_overflow,
    output logic           o_err_spurious
);

    logic [OCW-1:0]    occ_q [TREE_NUM];
    logic [OCW-1:0]    occ_d [TREE_NUM];
    logic [CRW-1:0]    credits_q, credits_d;
    logic [CRW-1:0]    outst_q, outst_d;
    logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [TNB+DW-1:0] mem_q [RSP_DEPTH];

    logic           push_q, pop_q;
    logic [TNB-1:0] push_tid_q, pop_tid_q;
    logic [DW-1:0]  push_data_q;
    logic           err_ovf_q, err_spur_q;

    logic [OCW-1:0]    occ_sel_s;
    logic              cmd_ready_s, push_acc_s, pop_acc_s;
    logic              fifo_empty_s, fifo_full_s, deq_s, cap_ok_s;
    logic              spur_s, ovf_s;
    logic [TNB+DW-1:0] rsp_entry_s;

    // Command acceptance and FIFO status decode
    always_comb begin
        occ_sel_s    = occ_q[i_cmd_tree_id];
        fifo_empty_s = (wptr_q == rptr_q);
        fifo_full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        if (i_task_fifo_full) begin
            cmd_ready_s = 1'b0;
        end else if (i_cmd_op) begin
            cmd_ready_s = (occ_sel_s < OCW'(TREE_CAP));
        end else begin
            cmd_ready_s = (occ_sel_s != {OCW{1'b0}}) && (credits_q != {CRW{1'b0}});
        end
        push_acc_s = i_cmd_valid && cmd_ready_s && i_cmd_op;
        pop_acc_s  = i_cmd_valid && cmd_ready_s && !i_cmd_op;
        deq_s      = !fifo_empty_s && i_rsp_ready;
        // A dequeue in the same cycle frees the slot a full-FIFO capture needs.
        cap_ok_s   = i_is_level0_pop && (!fifo_full_s || deq_s);
        ovf_s      = i_is_level0_pop && fifo_full_s && !deq_s;
        spur_s     = i_is_level0_pop && (outst_q == {CRW{1'b0}}) && !pop_acc_s;
    end

    // Next-state for occupancy, credits, outstanding pops and FIFO pointers
    always_comb begin
        occ_d = occ_q;
        if (push_acc_s) begin
            occ_d[i_cmd_tree_id] = occ_sel_s + OCW'(1'b1);
        end else if (pop_acc_s) begin
            occ_d[i_cmd_tree_id] = occ_sel_s - OCW'(1'b1);
        end else begin
            occ_d[i_cmd_tree_id] = occ_sel_s;
        end

        case ({pop_acc_s, deq_s})
            2'b10:   credits_d = credits_q - CRW'(1'b1);
            2'b01:   credits_d = (credits_q < CRW'(RSP_DEPTH)) ? credits_q + CRW'(1'b1) : credits_q;
            default: credits_d = credits_q;
        endcase

        case ({pop_acc_s, i_is_level0_pop})
            2'b10:   outst_d = outst_q + CRW'(1'b1);
            2'b01:   outst_d = (outst_q != {CRW{1'b0}}) ? outst_q - CRW'(1'b1) : outst_q;
            default: outst_d = outst_q;
        endcase

        if (cap_ok_s) begin
            wptr_d = wptr_q + (AW+1)'(1'b1);
        end else begin
            wptr_d = wptr_q;
        end
        if (deq_s) begin
            rptr_d = rptr_q + (AW+1)'(1'b1);
        end else begin
            rptr_d = rptr_q;
        end
    end

    // State registers and registered task strobes
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int t = 0; t < TREE_NUM; t++) begin
                occ_q[t] <= {OCW{1'b0}};
            end
            for (int e = 0; e < RSP_DEPTH; e++) begin
                mem_q[e] <= {(TNB+DW){1'b0}};
            end
            credits_q   <= CRW'(RSP_DEPTH);
            outst_q     <= {CRW{1'b0}};
            wptr_q      <= {(AW+1){1'b0}};
            rptr_q      <= {(AW+1){1'b0}};
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            push_tid_q  <= {TNB{1'b0}};
            pop_tid_q   <= {TNB{1'b0}};
            push_data_q <= {DW{1'b0}};
            err_ovf_q   <= 1'b0;
            err_spur_q  <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            credits_q   <= credits_d;
            outst_q     <= outst_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            if (cap_ok_s) begin
                mem_q[wptr_q[AW-1:0]] <= {i_tree_id, i_pop_data};
            end
            push_q      <= push_acc_s;
            pop_q       <= pop_acc_s;
            push_tid_q  <= push_acc_s ? i_cmd_tree_id : {TNB{1'b0}};
            pop_tid_q   <= pop_acc_s  ? i_cmd_tree_id : {TNB{1'b0}};
            push_data_q <= push_acc_s ? i_cmd_data    : {DW{1'b0}};
            err_ovf_q   <= err_ovf_q  | ovf_s;
            err_spur_q  <= err_spur_q | spur_s;
        end
    end

    assign rsp_entry_s    = mem_q[rptr_q[AW-1:0]];
    assign o_cmd_ready    = cmd_ready_s;
    assign o_push         = push_q;
    assign o_pop          = pop_q;
    assign o_push_tree_id = push_tid_q;
    assign o_pop_tree_id  = pop_tid_q;
    assign o_push_data    = push_data_q;
    assign o_rsp_valid    = !fifo_empty_s;
    assign o_rsp_tree_id  = rsp_entry_s[TNB+DW-1:DW];
    assign o_rsp_data     = rsp_entry_s[DW-1:0];
    assign o_rsp_null     = &rsp_entry_s[DW-1:0];
    assign o_err_overflow = err_ovf_q;
    assign o_err_spurious = err_spur_q;

endmodule
